// File: rtl/io_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_responder
// Purpose  : IO-window bus target with a scratch register, a read-only ID
//            register and an optional compare timer that raises a level irq.
//            b_data_o is zero outside the ack cycle so several responders
//            can share the bus through a plain OR.
// Options  : IO_RESP_TIMER_EN - when defined, builds COUNT/CMP/CTRL and irq.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_responder #(
  parameter logic [23:0] BASE_ADDR   = 24'h400000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h48460001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_data_i,
  input  logic        b_read_i,
  input  logic        b_write_i,
  output logic [31:0] b_data_o,
  output logic        b_ack_o,
  output logic        irq_o
);

  localparam logic [3:0] C_WAIT = WAIT_CYCLES[3:0];

  localparam logic [5:0] C_W_SCRATCH = 6'h00;
  localparam logic [5:0] C_W_ID      = 6'h04;
`ifdef IO_RESP_TIMER_EN
  localparam logic [5:0] C_W_COUNT   = 6'h01;
  localparam logic [5:0] C_W_CMP     = 6'h02;
  localparam logic [5:0] C_W_CTRL    = 6'h03;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic [5:0]  r_word;
  logic [31:0] r_wdata;
  logic        r_wr;
  logic [31:0] r_scratch;

  logic        w_req;
  logic        w_latch;
  logic        w_commit;
  logic [31:0] w_rdata;

  // Byte-lane bits of the address carry no meaning for word registers.
  logic        w_unused;
  assign w_unused = &{1'b0, b_addr_i[1:0]};

  assign w_req    = (b_read_i | b_write_i) & (b_addr_i[31:8] == BASE_ADDR);
  assign w_latch  = (r_state == S_IDLE) & w_req;
  assign w_commit = (r_state == S_ACK) & r_wr;

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: a dropped request while waiting abandons the access.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (C_WAIT == 4'd0) begin
            w_state_nxt = S_ACK;
          end else begin
            w_cnt_nxt   = C_WAIT;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the transaction on acceptance; read+write together counts as write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word  <= 6'd0;
      r_wdata <= 32'd0;
      r_wr    <= 1'b0;
    end else if (w_latch) begin
      r_word  <= b_addr_i[7:2];
      r_wdata <= b_data_i;
      r_wr    <= b_write_i;
    end
  end

  // Scratch register, written when the ack cycle closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scratch <= 32'd0;
    end else if (w_commit && (r_word == C_W_SCRATCH)) begin
      r_scratch <= r_wdata;
    end
  end

`ifdef IO_RESP_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic        r_en;
  logic        r_ie;
  logic        r_match;
  logic        r_irq;
  logic        w_match_set;
  logic        w_match_clr;
  logic        w_wr_ctrl;

  assign w_wr_ctrl   = w_commit & (r_word == C_W_CTRL);
  assign w_match_set = r_en & (r_count == r_cmp);
  assign w_match_clr = w_wr_ctrl & r_wdata[2];

  // Free-running counter; a bus write takes priority over the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (w_commit && (r_word == C_W_COUNT)) begin
      r_count <= r_wdata;
    end else if (r_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  // Compare value and control bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp <= 32'd0;
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
    end else begin
      if (w_commit && (r_word == C_W_CMP)) begin
        r_cmp <= r_wdata;
      end
      if (w_wr_ctrl) begin
        r_en <= r_wdata[0];
        r_ie <= r_wdata[1];
      end
    end
  end

  // Sticky match flag (a new match beats a W1C clear) and registered irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_match <= w_match_set | (r_match & ~w_match_clr);
      r_irq   <= r_match & r_ie;
    end
  end

  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux on the latched word offset; unmapped offsets read zero.
  always_comb begin
    w_rdata = 32'd0;
    case (r_word)
      C_W_SCRATCH: w_rdata = r_scratch;
      C_W_ID:      w_rdata = ID_VALUE;
`ifdef IO_RESP_TIMER_EN
      C_W_COUNT:   w_rdata = r_count;
      C_W_CMP:     w_rdata = r_cmp;
      C_W_CTRL:    w_rdata = {29'd0, r_match, r_ie, r_en};
`endif
      default:     w_rdata = 32'd0;
    endcase
  end

  assign b_ack_o  = (r_state == S_ACK);
  assign b_data_o = b_ack_o ? w_rdata : 32'd0;

endmodule
`default_nettype wire
